// File: rtl/audio_dac_serializer_if.sv
// Sample-pair valid/ready handshake between the audio producer and the I2S DAC serializer.
interface audio_dac_serializer_if #(
    parameter int SAMPLE_WIDTH = 16
) ();
    logic [SAMPLE_WIDTH-1:0] in_left;
    logic [SAMPLE_WIDTH-1:0] in_right;
    logic                    in_valid;
    logic                    in_ready;

    modport master (output in_left, output in_right, output in_valid, input in_ready);
    modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/audio_dac_serializer.sv
// I2S master transmitter for the WM8731 DAC: one-pair skid register, BCLK/LRCK generation, serial shifter.
// Optional AUDIO_DAC_HOLD_ON_UNDERRUN_EN repeats the last pair on underrun instead of muting.
module audio_dac_serializer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32,
    parameter int BCLK_HALF    = 12
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    audio_dac_serializer_if.slave  sink,
    output logic                   AUD_BCLK,
    output logic                   AUD_DACLRCK,
    output logic                   AUD_DACDAT,
    output logic                   frame_start,
    output logic                   underrun
);
    localparam int DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int PAIR_W = 2 * SAMPLE_WIDTH;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

    logic [DIV_W-1:0]  div_cnt_r,     div_cnt_s;
    logic              bclk_r,        bclk_s;
    logic [BIT_W-1:0]  bit_cnt_r,     bit_cnt_s;
    logic              lrck_r,        lrck_s;
    logic              dacdat_r,      dacdat_s;
    logic              frame_start_r, frame_start_s;
    logic              underrun_r,    underrun_s;
    logic              in_ready_r,    in_ready_s;
    logic              skid_full_r,   skid_full_s;
    logic [PAIR_W-1:0] skid_pair_r,   skid_pair_s;
    logic [PAIR_W-1:0] frame_pair_r,  frame_pair_s;
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
    logic [PAIR_W-1:0] last_pair_r,   last_pair_s;
`endif

    logic bclk_tick_s;
    logic fall_s;
    logic wrap_s;
    logic load_s;
    logic accept_s;

    // Slot k carries ch[SAMPLE_WIDTH-k] for k in 1..SAMPLE_WIDTH; slot 0 (I2S delay bit) and padding slots are 0.
    function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0] ch, input logic [BIT_W-1:0] k);
        logic b;
        b = 1'b0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            b = (int'(k) == (SAMPLE_WIDTH - i)) ? ch[i] : b;
        end
        return b;
    endfunction

    // Next-state logic: bit-clock divider, slot/channel sequencing, skid handshake and frame load.
    always_comb begin
        div_cnt_s     = div_cnt_r;
        bclk_s        = bclk_r;
        bit_cnt_s     = bit_cnt_r;
        lrck_s        = lrck_r;
        dacdat_s      = dacdat_r;
        frame_start_s = 1'b0;
        underrun_s    = 1'b0;
        skid_full_s   = skid_full_r;
        skid_pair_s   = skid_pair_r;
        frame_pair_s  = frame_pair_r;
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
        last_pair_s   = last_pair_r;
`endif

        bclk_tick_s = (div_cnt_r == DIV_LAST);
        fall_s      = bclk_tick_s && bclk_r;
        wrap_s      = fall_s && (bit_cnt_r == BIT_LAST);
        load_s      = wrap_s && lrck_r;
        accept_s    = sink.in_valid && in_ready_r;

        if (bclk_tick_s) begin
            div_cnt_s = {DIV_W{1'b0}};
            bclk_s    = ~bclk_r;
        end else begin
            div_cnt_s = div_cnt_r + DIV_W'(1);
            bclk_s    = bclk_r;
        end

        if (wrap_s) begin
            bit_cnt_s = {BIT_W{1'b0}};
            lrck_s    = ~lrck_r;
        end else if (fall_s) begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            lrck_s    = lrck_r;
        end else begin
            bit_cnt_s = bit_cnt_r;
            lrck_s    = lrck_r;
        end

        // A load needs a full skid and an accept needs an empty one, so the two never collide.
        if (load_s && skid_full_r) begin
            skid_full_s = 1'b0;
        end else if (accept_s) begin
            skid_full_s = 1'b1;
            skid_pair_s = {sink.in_left, sink.in_right};
        end else begin
            skid_full_s = skid_full_r;
        end

        if (load_s) begin
            frame_start_s = 1'b1;
            if (skid_full_r) begin
                frame_pair_s = skid_pair_r;
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
                last_pair_s  = skid_pair_r;
`endif
            end else begin
                underrun_s   = 1'b1;
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
                frame_pair_s = last_pair_r;
`else
                frame_pair_s = {PAIR_W{1'b0}};
`endif
            end
        end else begin
            frame_start_s = 1'b0;
        end

        if (fall_s) begin
            dacdat_s = slot_bit(lrck_s ? frame_pair_s[SAMPLE_WIDTH-1:0]
                                       : frame_pair_s[PAIR_W-1:SAMPLE_WIDTH], bit_cnt_s);
        end else begin
            dacdat_s = dacdat_r;
        end

        in_ready_s = ~skid_full_s;
    end

    // State and output registers; reset restarts the frame and discards any held pair.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_cnt_r     <= {DIV_W{1'b0}};
            bclk_r        <= 1'b0;
            bit_cnt_r     <= BIT_LAST;
            lrck_r        <= 1'b1;
            dacdat_r      <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
            in_ready_r    <= 1'b1;
            skid_full_r   <= 1'b0;
            skid_pair_r   <= {PAIR_W{1'b0}};
            frame_pair_r  <= {PAIR_W{1'b0}};
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
            last_pair_r   <= {PAIR_W{1'b0}};
`endif
        end else begin
            div_cnt_r     <= div_cnt_s;
            bclk_r        <= bclk_s;
            bit_cnt_r     <= bit_cnt_s;
            lrck_r        <= lrck_s;
            dacdat_r      <= dacdat_s;
            frame_start_r <= frame_start_s;
            underrun_r    <= underrun_s;
            in_ready_r    <= in_ready_s;
            skid_full_r   <= skid_full_s;
            skid_pair_r   <= skid_pair_s;
            frame_pair_r  <= frame_pair_s;
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
            last_pair_r   <= last_pair_s;
`endif
        end
    end

    assign sink.in_ready = in_ready_r;
    assign AUD_BCLK      = bclk_r;
    assign AUD_DACLRCK   = lrck_r;
    assign AUD_DACDAT    = dacdat_r;
    assign frame_start   = frame_start_r;
    assign underrun      = underrun_r;
endmodule
